// File: rtl/mem_burst_reader.sv
// Read-DMA engine: turns a (start address, word count) command into one memory read per cycle,
// buffers returned words in a fall-through FIFO and streams them out under credit-based flow control.
module mem_burst_reader #(
    parameter int BUS_WIDTH_BITS  = 64,
    parameter int ADDR_WIDTH_BITS = 64,
    parameter int LEN_WIDTH       = 16,
    parameter int READ_LATENCY    = 1,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [ADDR_WIDTH_BITS-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]       cmd_len,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BUS_WIDTH_BITS-1:0]  out_data,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_WIDTH_BITS-1:0] mem_addr,
    output logic [BUS_WIDTH_BITS-1:0]  mem_wdata,
    output logic                       mem_wen,
    input  logic [BUS_WIDTH_BITS-1:0]  mem_rdata,
    input  logic                       mem_rvalid,
    output logic [1:0]                 fsm_state
);
    localparam int STRIDE = BUS_WIDTH_BITS / 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                     state, state_next;
    logic [ADDR_WIDTH_BITS-1:0] next_addr;
    logic [LEN_WIDTH-1:0]       issue_left;
    logic [LEN_WIDTH-1:0]       out_left;
    logic [READ_LATENCY-1:0]    tags;
    logic [BUS_WIDTH_BITS-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           rd_ptr, wr_ptr;
    logic [CNT_W-1:0]           fifo_count, inflight;
    logic                       accept, issue, push, pop, credit_ok;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign fsm_state = state;
    assign mem_wen   = 1'b0;
    assign mem_wdata = '0;

    assign accept    = cmd_ready && cmd_valid;
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = tags[READ_LATENCY-1] && mem_rvalid;
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
    assign out_last  = out_valid && (out_left == LEN_WIDTH'(1));

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CNT_W'(tags[i]);
        end
    end

    // Credit uses the start-of-cycle fill level, so a same-cycle pop does not free a slot.
    assign credit_ok = (fifo_count + inflight) < CNT_W'(FIFO_DEPTH);
    assign issue     = (state == ISSUE) && (issue_left != '0) && credit_ok;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (cmd_len == '0) ? DONE : ISSUE;
            ISSUE:   if (issue && issue_left == LEN_WIDTH'(1)) state_next = DRAIN;
            DRAIN:   if (pop && out_left == LEN_WIDTH'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            next_addr  <= '0;
            issue_left <= '0;
            out_left   <= '0;
            mem_addr   <= '0;
            tags       <= '0;
        end else begin
            state <= state_next;
            tags  <= (tags << 1) | READ_LATENCY'(issue);
            if (accept) begin
                next_addr  <= cmd_addr & ~ADDR_WIDTH_BITS'(STRIDE - 1);
                issue_left <= cmd_len;
                out_left   <= cmd_len;
            end else begin
                if (issue) begin
                    mem_addr   <= next_addr;
                    next_addr  <= next_addr + ADDR_WIDTH_BITS'(STRIDE);
                    issue_left <= issue_left - LEN_WIDTH'(1);
                end
                if (pop) out_left <= out_left - LEN_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage carries no reset; out_data is gated to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mem_rdata;
    end
endmodule

// File: tb/tb_mem_burst_reader.sv
// Randomized bench for mem_burst_reader: a word-indexed memory (mem[i] = i), a command-level
// reference model feeding an expected queue, and a negedge monitor that pops and compares.
module tb_mem_burst_reader;
    localparam int BW = 64;
    localparam int AW = 64;
    localparam int LW = 16;
    localparam int RL = 1;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_wdata;
    logic          mem_wen;
    logic [BW-1:0] mem_rdata;
    logic          mem_rvalid;
    logic [1:0]    fsm_state;

    mem_burst_reader #(
        .BUS_WIDTH_BITS(BW), .ADDR_WIDTH_BITS(AW), .LEN_WIDTH(LW),
        .READ_LATENCY(RL), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .fsm_state(fsm_state)
    );

    // Clock, cycle counter and behavioural memory (word i holds i).
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    assign mem_rdata  = BW'(mem_addr / (BW / 8));
    assign mem_rvalid = 1'b1;

    int checks = 0;
    int failures = 0;
    logic [BW:0] exp_q[$];
    int pop_count = 0;
    int first_valid_cyc = -1;
    int last_pop_cyc = -1;
    int done_cyc = -1;
    int done_cnt = 0;
    int max_fill = 0;
    int acc_cyc = 0;
    bit rand_ready = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Reference model: a command expands into the word indices of its aligned, wrapping address run.
    task automatic model_cmd(input logic [AW-1:0] addr, input int len);
        logic [AW-1:0] a;
        a = addr & ~AW'(BW / 8 - 1);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({(i == len - 1), BW'(a / (BW / 8))});
            a = a + AW'(BW / 8);
        end
    endtask

    task automatic send_cmd(input logic [AW-1:0] addr, input int len);
        int n;
        n = 0;
        while (!cmd_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("cmd_ready_before_send", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = LW'(len);
        pop_count = 0;
        first_valid_cyc = -1;
        last_pop_cyc = -1;
        model_cmd(addr, len);
        @(posedge clk); #1;
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int len);
        int start_cnt;
        int n;
        start_cnt = done_cnt;
        n = 0;
        while (done_cnt == start_cnt && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, done_cnt, start_cnt + 1);
        @(negedge clk);
        check({name, "_done_width"}, done, 1'b0);
        check({name, "_words"}, pop_count, len);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        if (len > 0) check({name, "_done_after_last_pop"}, done_cyc, last_pop_cyc + 1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_cmd_ready"}, cmd_ready, 1'b1);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_done"}, done, 1'b0);
        check({name, "_out_valid"}, out_valid, 1'b0);
        check({name, "_out_last"}, out_last, 1'b0);
        check({name, "_out_data"}, out_data, '0);
        check({name, "_mem_addr"}, mem_addr, '0);
        check({name, "_mem_wen"}, mem_wen, 1'b0);
        check({name, "_mem_wdata"}, mem_wdata, '0);
    endtask

    // Monitor: pops the expected queue on every accepted output word.
    always @(negedge clk) begin
        logic [BW:0] e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", out_data, '1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e[BW-1:0]);
                    check("out_last", out_last, e[BW]);
                end
                pop_count++;
                last_pop_cyc = cyc;
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (int'(dut.fifo_count) > max_fill) max_fill = int'(dut.fifo_count);
        end
    end

    always @(negedge clk) begin
        if (rst_n && dut.tags[RL-1]) assert (mem_rvalid) else $error("read tag emerged without mem_rvalid");
    end

    always @(posedge clk) begin
        #2;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n;
        // Reset held for three cycles.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic burst: words 8..11, back to back from cycle 3.
        out_ready = 1'b1;
        send_cmd(64'h40, 4);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("basic_mem_addr", mem_addr, 64'h40 + 64'(8 * k));
        end
        wait_done("basic", 4);
        check("basic_first_valid_cycle", first_valid_cyc, acc_cyc + 2);
        check("basic_last_pop_cycle", last_pop_cyc, acc_cyc + 5);
        check("basic_done_cycle", done_cyc, acc_cyc + 6);

        // Backpressure: only FIFO_DEPTH reads may issue.
        out_ready = 1'b0;
        send_cmd(64'h0, 10);
        repeat (8) @(negedge clk);
        check("bp_mem_addr_a", mem_addr, 64'h18);
        repeat (4) @(negedge clk);
        check("bp_mem_addr_b", mem_addr, 64'h18);
        check("bp_out_valid", out_valid, 1'b1);
        check("bp_head", out_data, 64'h0);
        check("bp_busy", busy, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done("bp", 10);

        // Zero length: done in cycle 1, no output.
        send_cmd(64'h100, 0);
        @(negedge clk);
        check("zero_done_cycle1", done, 1'b1);
        wait_done("zero", 0);
        repeat (3) @(negedge clk);
        check("zero_no_output", first_valid_cyc, -1);

        // Busy rejection during a 16-word burst.
        send_cmd(64'h200, 16);
        repeat (3) @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_addr  = 64'h1000;
        cmd_len   = 16'd5;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("busy_cmd_ready", cmd_ready, 1'b0);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_done("busy_reject", 16);
        repeat (4) @(negedge clk);
        check("busy_reject_idle", busy, 1'b0);
        check("busy_reject_no_valid", out_valid, 1'b0);

        // Random out_ready, unaligned start address.
        rand_ready = 1;
        send_cmd(64'h7, 100);
        @(negedge clk);
        @(negedge clk);
        check("rand_first_addr", mem_addr, 64'h0);
        wait_done("rand100", 100);
        for (int c = 0; c < 4; c++) begin
            logic [AW-1:0] ra;
            int rlen;
            ra   = {32'($urandom), 32'($urandom)};
            rlen = $urandom_range(1, 24);
            send_cmd(ra, rlen);
            wait_done("rand_cmd", rlen);
        end
        @(posedge clk); #1;
        rand_ready = 0;
        out_ready  = 1'b1;

        // Reset mid-burst after five words.
        send_cmd(64'h0, 20);
        n = 0;
        while (pop_count < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("midrst_words_before", pop_count, 5);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_no_done", done_cnt, d0);
        check("midrst_idle", out_valid, 1'b0);
        send_cmd(64'h0, 2);
        wait_done("after_rst", 2);

        check("max_fifo_fill_ok", (max_fill <= FD), 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
